// File: rtl/ocw1_mask_registers.sv
// ---------------------------------------------------------------------------
// ocw1_mask_registers
//
// Interrupt mask (IMR) and special mask (ISMR) registers loaded through OCW1.
// Each register is NUM_IRQ bits wide and is written as a sequence of
// DATA_WIDTH-wide bytes, least significant slice first. The leading bytes are
// held in a staging register. The final byte commits the whole word at once,
// so a partially written value never reaches the mask outputs. A byte-wise
// readback pointer walks the committed register that special_mask_mode
// selects.
//
// Ports
//   clock                                    system clock, rising-edge active
//   reset_n                                  asynchronous active-low reset
//   write_initial_command_word_1             ICW1 level: clears masks, aborts
//   write_operation_control_word_1_registers OCW1 write level, one byte/rise
//   special_mask_mode                        0 = IMR, 1 = ISMR
//   internal_data_bus                        write data byte
//   read_operation_control_word_1            readback level, advance on fall
//   read_data                                currently selected readback byte
//   interrupt_mask                           committed IMR
//   interrupt_special_mask                   committed ISMR
//   write_in_progress                        a sequence is partially staged
// ---------------------------------------------------------------------------
module ocw1_mask_registers #(
  parameter int NUM_IRQ    = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_initial_command_word_1,
  input  logic                  write_operation_control_word_1_registers,
  input  logic                  special_mask_mode,
  input  logic [DATA_WIDTH-1:0] internal_data_bus,
  input  logic                  read_operation_control_word_1,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [NUM_IRQ-1:0]    interrupt_mask,
  output logic [NUM_IRQ-1:0]    interrupt_special_mask,
  output logic                  write_in_progress
);

  localparam int BYTES = NUM_IRQ / DATA_WIDTH;
  localparam int PW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [PW-1:0] LAST = PW'(BYTES - 1);

  logic                  wr_prev;
  logic                  rd_prev;
  logic                  target;
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [NUM_IRQ-1:0]    imr;
  logic [NUM_IRQ-1:0]    ismr;
  logic [NUM_IRQ-1:0]    staging;
  logic [NUM_IRQ-1:0]    commit_val;
  logic [NUM_IRQ-1:0]    read_sel;

  logic wr_edge;
  logic rd_fall;
  logic last_byte;
  logic seq_target;
  logic commit;

  assign wr_edge   = write_operation_control_word_1_registers & ~wr_prev;
  assign rd_fall   = ~read_operation_control_word_1 & rd_prev;
  assign last_byte = (wp == LAST);

  // The first byte of a sequence picks the target from the mode pin; later
  // bytes reuse the latched choice so mode changes mid-sequence are ignored.
  assign seq_target = (wp == '0) ? special_mask_mode : target;

  // ICW1 wins over a simultaneous write edge, so such a byte never commits.
  assign commit = wr_edge & last_byte & ~write_initial_command_word_1;

  // The committed word is the staged lower slices plus the live final byte.
  always_comb begin
    commit_val = staging;
    commit_val[NUM_IRQ-1 -: DATA_WIDTH] = internal_data_bus;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
      target  <= 1'b0;
      wp      <= '0;
      rp      <= '0;
      imr     <= '0;
      ismr    <= '0;
      staging <= '0;
    end else begin
      // Edge history keeps tracking the strobes even while ICW1 is held.
      wr_prev <= write_operation_control_word_1_registers;
      rd_prev <= read_operation_control_word_1;

      if (write_initial_command_word_1) begin
        wp      <= '0;
        rp      <= '0;
        imr     <= '0;
        ismr    <= '0;
        staging <= '0;
      end else begin
        if (wr_edge) begin
          target <= seq_target;
          if (last_byte) begin
            if (seq_target) ismr <= commit_val;
            else            imr  <= commit_val;
            wp <= '0;
          end else begin
            for (int k = 0; k < BYTES; k++) begin
              if (wp == PW'(k)) staging[k*DATA_WIDTH +: DATA_WIDTH] <= internal_data_bus;
            end
            wp <= wp + PW'(1);
          end
        end

        // A commit restarts readback at the low slice, overriding a read.
        if (commit) begin
          rp <= '0;
        end else if (rd_fall) begin
          rp <= (rp == LAST) ? '0 : rp + PW'(1);
        end
      end
    end
  end

  // Readback follows the mode pin combinationally over committed state only.
  always_comb begin
    read_sel  = special_mask_mode ? ismr : imr;
    read_data = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (rp == PW'(k)) read_data = read_sel[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign interrupt_mask         = imr;
  assign interrupt_special_mask = ismr;
  assign write_in_progress      = (wp != '0);

endmodule
